elm_output_accumulator: RTL and testbench

- Output-neuron sequencer and accumulator for the ELM inference engine.
- Sits directly downstream of the H*W21 shift-add `multiplier`. For each hidden neuron i it:
  - fetches H[i] and W21[i] from the hidden-output and weight buffers;
  - launches one `multiplier` operation;
  - waits the fixed multiply latency;
  - adds the signed product into a guarded accumulator.
- After the last neuron it saturates the sum (plus bias) to 21-bit Q5.15, presents it as the output score and pulses y_valid.

---
 rtl/elm_pkg.sv | 25 ++
 rtl/elm_sat_trunc.sv | 26 ++
 rtl/elm_output_accumulator.sv | 142 ++++++++++++++
 tb/tb_elm_output_accumulator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elm_pkg.sv
// Shared constants and state encoding for the ELM inference engine output stage.
package elm_pkg;

    localparam int N            = 21;
    localparam int FRAC         = 15;
    localparam int IDX_W        = 7;
    localparam int GUARD        = 6;
    localparam int MULT_LATENCY = 21;
    localparam int ACC_W        = N + GUARD;

    localparam logic [N-1:0] Q_MAX = 21'h0FFFFF;
    localparam logic [N-1:0] Q_MIN = 21'h100000;
    localparam logic [N-1:0] Q_ONE = 21'h08000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_ACCUM,
        S_DONE
    } state_t;

endpackage

// File: rtl/elm_sat_trunc.sv
// Combinational saturation of a guarded signed accumulator down to N bits, with clip flag.
module elm_sat_trunc #(
    parameter int N     = 21,
    parameter int ACC_W = 27
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [N-1:0]     y,
    output logic                    clipped
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    always_comb begin
        y       = acc[N-1:0];
        clipped = 1'b0;
        if (acc > MAX_V) begin
            y       = MAX_V[N-1:0];
            clipped = 1'b1;
        end else if (acc < MIN_V) begin
            y       = MIN_V[N-1:0];
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/elm_output_accumulator.sv
// Output-neuron sequencer: fetches H/W21 per hidden neuron, launches the shift-add
// multiplier, accumulates the products onto the bias and emits a saturated Q5.15 score.
module elm_output_accumulator
    import elm_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] num_hidden,
    input  logic [N-1:0]     bias,
    output logic [IDX_W-1:0] mem_idx,
    input  logic [N-1:0]     h_data,
    input  logic [N-1:0]     w_data,
    output logic [N-1:0]     mult_M,
    output logic [N-1:0]     mult_Q,
    output logic             mult_ready,
    input  logic [N-1:0]     mult_product,
    output logic [N-1:0]     y,
    output logic             y_valid,
    output logic             busy,
    output logic             sat_flag
);

    localparam int CNT_W = $clog2(MULT_LATENCY);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        n_q, n_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N-1:0]            m_q, m_d;
    logic [N-1:0]            q_q, q_d;
    logic [N-1:0]            y_q, y_d;
    logic                    sat_q, sat_d;
    logic                    y_valid_q, y_valid_d;

    logic [IDX_W-1:0]        idx_inc;
    logic [N-1:0]            sat_y;
    logic                    sat_clip;

    assign idx_inc = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        q_d     = q_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = num_hidden;
                    acc_d   = {{GUARD{bias[N-1]}}, bias};
                    idx_d   = '0;
                    state_d = (num_hidden == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                m_d     = h_data;
                q_d     = w_data;
                state_d = S_KICK;
            end
            S_KICK: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MULT_LATENCY - 1)) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d   = acc_q + {{GUARD{mult_product[N-1]}}, mult_product};
                idx_d   = idx_inc;
                state_d = (idx_inc == n_q) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Score is registered on entry to DONE so y and y_valid are both visible in the DONE cycle.
    elm_sat_trunc #(
        .N    (N),
        .ACC_W(ACC_W)
    ) u_sat (
        .acc    (acc_d),
        .y      (sat_y),
        .clipped(sat_clip)
    );

    always_comb begin
        y_d       = y_q;
        sat_d     = sat_q;
        y_valid_d = 1'b0;
        if (state_d == S_DONE) begin
            y_d       = sat_y;
            sat_d     = sat_clip;
            y_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            y_q       <= '0;
            sat_q     <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            q_q       <= q_d;
            y_q       <= y_d;
            sat_q     <= sat_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign mem_idx    = idx_q;
    assign mult_M     = m_q;
    assign mult_Q     = q_q;
    assign mult_ready = (state_q == S_KICK);
    assign busy       = (state_q != S_IDLE);
    assign y          = y_q;
    assign y_valid    = y_valid_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_elm_output_accumulator.sv
// Directed and randomized bench for elm_output_accumulator with behavioural
// buffer, multiplier and score models.
module tb_elm_output_accumulator;

    localparam int N   = 21;
    localparam int LAT = 21;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [6:0]    num_hidden = '0;
    logic [N-1:0]  bias = '0;
    logic [6:0]    mem_idx;
    logic [N-1:0]  h_data = '0;
    logic [N-1:0]  w_data = '0;
    logic [N-1:0]  mult_M;
    logic [N-1:0]  mult_Q;
    logic          mult_ready;
    logic [N-1:0]  mult_product = '0;
    logic [N-1:0]  y;
    logic          y_valid;
    logic          busy;
    logic          sat_flag;

    logic [N-1:0]  h_mem [0:127];
    logic [N-1:0]  w_mem [0:127];
    logic [N-1:0]  pend_m = '0;
    logic [N-1:0]  pend_q = '0;
    int            lat_cnt = 0;

    int compared   = 0;
    int mismatched = 0;

    elm_output_accumulator dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .num_hidden  (num_hidden),
        .bias        (bias),
        .mem_idx     (mem_idx),
        .h_data      (h_data),
        .w_data      (w_data),
        .mult_M      (mult_M),
        .mult_Q      (mult_Q),
        .mult_ready  (mult_ready),
        .mult_product(mult_product),
        .y           (y),
        .y_valid     (y_valid),
        .busy        (busy),
        .sat_flag    (sat_flag)
    );

    always #5 clock = ~clock;

    // Signed Q5.15 product, truncated back to 21 bits.
    function automatic logic [N-1:0] q_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        return N'(p >>> 15);
    endfunction

    // Expected score: bias plus all products, clipped to the Q5.15 range.
    function automatic void ref_score(input int n, input logic [N-1:0] b,
                                      output logic [N-1:0] ey, output logic eclip);
        longint sum;
        sum = longint'(signed'(b));
        for (int i = 0; i < n; i++) begin
            sum += longint'(signed'(q_mul(h_mem[i], w_mem[i])));
        end
        eclip = 1'b1;
        if (sum > 64'sd1048575)       ey = 21'h0FFFFF;
        else if (sum < -64'sd1048576) ey = 21'h100000;
        else begin
            ey    = N'(sum);
            eclip = 1'b0;
        end
    endfunction

    always @(posedge clock) begin
        h_data <= h_mem[mem_idx];
        w_data <= w_mem[mem_idx];
    end

    // Product is garbage until LAT edges after the launch edge.
    always @(posedge clock) begin
        if (reset) begin
            lat_cnt <= 0;
        end else if (mult_ready) begin
            pend_m       <= mult_M;
            pend_q       <= mult_Q;
            lat_cnt      <= LAT;
            mult_product <= N'($urandom);
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) mult_product <= q_mul(pend_m, pend_q);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int n, input logic [N-1:0] b,
                                 input bit disturb, input int reset_at);
        logic [N-1:0] ey;
        logic         eclip;
        int           c;
        int           ready_cnt;
        bit           seen;
        ref_score(n, b, ey, eclip);
        @(negedge clock);
        num_hidden = 7'(n);
        bias       = b;
        start      = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        c         = 1;
        ready_cnt = 0;
        seen      = 1'b0;
        while (c <= 25 * n + 10) begin
            if (mult_ready) ready_cnt++;
            if (c == 1) checkOutput("busy_after_start", 32'(busy), 32'd1);
            if (((c - 1) % 25 == 0) && (c <= 25 * n))
                checkOutput("mem_idx", 32'(mem_idx), 32'((c - 1) / 25));
            if (disturb && c == 10) begin
                start      = 1'b1;
                num_hidden = 7'($urandom_range(0, 127));
                bias       = N'($urandom);
            end
            if (disturb && c == 11) start = 1'b0;
            if (c == reset_at) begin
                reset = 1'b1;
                @(posedge clock);
                #1;
                checkOutput("reset_busy", 32'(busy), 32'd0);
                checkOutput("reset_y", 32'(y), 32'd0);
                checkOutput("reset_mult_ready", 32'(mult_ready), 32'd0);
                checkOutput("reset_y_valid", 32'(y_valid), 32'd0);
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            if (y_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
            c++;
        end
        if (!seen) begin
            checkOutput("y_valid_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("latency", 32'(c), 32'(25 * n + 1));
            checkOutput("y", 32'(y), 32'(ey));
            checkOutput("sat_flag", 32'(sat_flag), 32'(eclip));
            checkOutput("ready_pulses", 32'(ready_cnt), 32'(n));
            @(negedge clock);
            checkOutput("y_valid_pulse", 32'(y_valid), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("y_hold", 32'(y), 32'(ey));
        end
    endtask

    task automatic load_case1();
        h_mem[0] = 21'h08000;
        w_mem[0] = 21'h04000;
    endtask

    task automatic load_case2();
        h_mem[0] = 21'h08000;  w_mem[0] = 21'h04000;
        h_mem[1] = 21'h1F8000; w_mem[1] = 21'h04000;
        h_mem[2] = 21'h02000;  w_mem[2] = 21'h08000;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            h_mem[i] = '0;
            w_mem[i] = '0;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rst_y", 32'(y), 32'd0);
        checkOutput("rst_y_valid", 32'(y_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mult_ready", 32'(mult_ready), 32'd0);
        checkOutput("rst_sat_flag", 32'(sat_flag), 32'd0);
        checkOutput("rst_mem_idx", 32'(mem_idx), 32'd0);

        $display("[TB] single neuron");
        load_case1();
        applyStimulus(1, 21'h0, 1'b0, 0);

        $display("[TB] three neurons with bias");
        load_case2();
        applyStimulus(3, 21'h08000, 1'b0, 0);

        $display("[TB] positive saturation");
        for (int i = 0; i < 4; i++) begin
            h_mem[i] = 21'h20000;
            w_mem[i] = 21'h20000;
        end
        applyStimulus(4, 21'h0, 1'b0, 0);

        $display("[TB] negative saturation");
        for (int i = 0; i < 4; i++) w_mem[i] = 21'h1E0000;
        applyStimulus(4, 21'h0, 1'b0, 0);

        $display("[TB] zero neurons");
        applyStimulus(0, 21'h1FC000, 1'b0, 0);

        $display("[TB] reset in WAIT of neuron 2, then fresh run");
        load_case2();
        applyStimulus(3, 21'h08000, 1'b0, 30);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        load_case1();
        applyStimulus(1, 21'h0, 1'b0, 0);

        $display("[TB] start and inputs disturbed mid-run");
        load_case2();
        applyStimulus(3, 21'h08000, 1'b1, 0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                h_mem[i] = N'($urandom);
                w_mem[i] = N'($urandom);
            end
            applyStimulus(n, N'($urandom), r[0], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
